gf180mcu_fd_sc_mcu7t5v0__clkbr_arb4: RTL and testbench
======================================================

GF180MCU_FD_SC_MCU7T5V0__CLKBR_ARB4 -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__clkbr_arb4

Interface
REQ-001 SHALL have parameter WAKE_CYC, default 2: number of cycles E is high before GNT asserts (clock-branch settle time); legal range 1..255.
REQ-002 SHALL have parameter MAX_HOLD, default 16: number of GRANT-state cycles after which the owner is preempted (only with the preemption feature); legal range 1..255.
REQ-003 SHALL have parameter DRAIN_CYC, default 1: number of cycles with E low and no GNT between owners; legal range 1..255.
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port REQ, input, 4 bits: per-requester request for the shared gated clock branch; level, held until released.
REQ-007 SHALL have port GNT, output, 4 bits: one-hot-or-zero grant; the branch clock is valid for the owner while its bit is high.
REQ-008 SHALL have port E, output, 1 bit: enable to the clock-gate/clkinv branch driver.
REQ-009 SHALL have port BUSY, output, 1 bit: high in every state except IDLE.

Function
REQ-010 SHALL implement four states: IDLE, WAKE, GRANT and DRAIN; all outputs SHALL be registered and SHALL be decoded from the state and OWNER.
REQ-011 In IDLE with REQ nonzero, the block SHALL pick OWNER as the first set REQ bit at or after PTR, scanning upward modulo 4, set E=1, and go to WAKE at that edge.
REQ-012 In WAKE, E SHALL stay high; after WAKE_CYC edges in WAKE, GNT[OWNER] SHALL rise and the state SHALL go to GRANT. GNT therefore rises exactly WAKE_CYC edges after E rises.
REQ-013 If REQ[OWNER] falls during WAKE, the block SHALL abort to DRAIN at the next edge with E=0 and without ever asserting GNT.
REQ-014 In GRANT, the hold counter SHALL increment each cycle and saturate at MAX_HOLD.
REQ-015 In GRANT, when REQ[OWNER] is sampled low, GNT and E SHALL both clear at that edge and the state SHALL go to DRAIN.
REQ-016 On every entry to DRAIN, PTR SHALL become (OWNER+1) mod 4.
REQ-017 DRAIN SHALL last exactly DRAIN_CYC cycles with E=0 and GNT=0, then go to IDLE; IDLE re-arbitrates in its first cycle.
REQ-018 Requests arriving in any non-IDLE state SHALL be held pending, never dropped, and SHALL be considered at the next IDLE arbitration.
REQ-019 REQ changes on non-owner bits SHALL NOT affect the current owner, except through preemption (REQ-027).
REQ-020 GNT SHALL never have more than one bit set.
REQ-021 GNT SHALL never be high while E is low.
REQ-022 Counters SHALL be 8 bits and SHALL never wrap.

Reset
REQ-023 Assertion of RST SHALL immediately, independent of CLK, force state to IDLE, GNT=0, E=0, BUSY=0, PTR=0, OWNER=0 and all counters to 0.
REQ-024 RST asserted mid-grant SHALL drop GNT and E asynchronously; no DRAIN SHALL be performed.
REQ-025 After RST deasserts, arbitration SHALL start at the first rising edge that samples RST low.

Configuration
REQ-026 The macro GF180MCU_FD_SC_MCU7T5V0_CLKBR_ARB_PREEMPT_EN SHALL compile preemption in or out.
REQ-027 With the macro defined, if the hold counter equals MAX_HOLD and any non-owner REQ bit is high, the block SHALL take the REQ-015 exit at that edge.
REQ-028 Without the macro, the owner SHALL hold GNT until it drops REQ, MAX_HOLD SHALL be ignored, and no preemption logic SHALL exist.

Verification
REQ-029 Single request: WAKE_CYC=2, REQ=0001 from edge 0 -> E rises at edge 1, GNT=0001 at edge 3; REQ drops before edge 10 -> GNT=0, E=0 at edge 10, BUSY falls at edge 11.
REQ-030 Round robin: REQ=1111 held, owners released after each grant -> grant order 0,1,2,3,0.
REQ-031 WAKE abort: REQ[2] raised, then dropped one cycle later -> GNT stays 0000, DRAIN entered, PTR=3.
REQ-032 Preemption, macro defined, MAX_HOLD=4: REQ[0] held, REQ[3] raised -> GNT[0] drops after 4 GRANT cycles, GNT[3] follows DRAIN_CYC+1+WAKE_CYC edges later. Macro undefined -> GNT[0] held indefinitely.
REQ-033 Reset mid-GRANT: RST pulsed between clock edges -> GNT=0, E=0, BUSY=0 immediately; first grant after release goes to the lowest set REQ bit.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkbr_arb4_if.sv
// Request/grant bundle between four clock-branch consumers and the branch arbiter.
// master = requester side, slave = arbiter side.
interface gf180mcu_fd_sc_mcu7t5v0__clkbr_arb4_if;
   logic [3:0] REQ;
   logic [3:0] GNT;
   logic       E;
   logic       BUSY;

   modport master (output REQ, input GNT, input E, input BUSY);
   modport slave  (input REQ, output GNT, output E, output BUSY);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkbr_arb4.sv
// Round-robin arbiter for one shared gated clock branch: wakes the branch driver (E),
// then grants a single owner. Preemption compiled in by GF180MCU_FD_SC_MCU7T5V0_CLKBR_ARB_PREEMPT_EN.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | branch off, arbitrate among REQ starting at ptr
//   S_WAKE  | E high, waiting WAKE_CYC edges for the branch to settle
//   S_GRANT | E high, GNT[owner] high, hold counter running
//   S_DRAIN | E low, no grant, DRAIN_CYC edges before re-arbitration
module gf180mcu_fd_sc_mcu7t5v0__clkbr_arb4 #(
   parameter int WAKE_CYC  = 2,
   parameter int MAX_HOLD  = 16,
   parameter int DRAIN_CYC = 1
) (
   input  logic                                    CLK,
   input  logic                                    RST,
   gf180mcu_fd_sc_mcu7t5v0__clkbr_arb4_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAKE  = 2'd1,
      S_GRANT = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   // Down-counter load values: the transition fires when the counter reaches zero.
   localparam logic [7:0] WAKE_LD  = 8'(WAKE_CYC - 1);
   localparam logic [7:0] DRAIN_LD = 8'(DRAIN_CYC - 1);
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   state_t     state_q, state_d;
   logic [1:0] owner_q, owner_d;
   logic [1:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] hold_q, hold_d;
   logic [3:0] gnt_q, gnt_d;
   logic       e_q, e_d;
   logic       busy_q, busy_d;
   logic       owner_req;
   logic       release_now;

   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] idx;
      logic [1:0] pick;
      logic       found;
      pick  = ptr;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign owner_req = bus.REQ[owner_q];

`ifdef GF180MCU_FD_SC_MCU7T5V0_CLKBR_ARB_PREEMPT_EN
   logic [3:0] owner_oh;
   logic       preempt;
   always_comb begin
      owner_oh          = 4'b0000;
      owner_oh[owner_q] = 1'b1;
   end
   assign preempt     = (hold_q == HOLD_MAX) && |(bus.REQ & ~owner_oh);
   assign release_now = !owner_req || preempt;
`else
   assign release_now = !owner_req;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         owner_q <= 2'd0;
         ptr_q   <= 2'd0;
         cnt_q   <= 8'd0;
         hold_q  <= 8'd0;
         gnt_q   <= 4'b0000;
         e_q     <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
         e_q     <= e_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      case (state_q)
         S_IDLE: begin
            if (|bus.REQ) begin
               owner_d = rr_pick(bus.REQ, ptr_q);
               cnt_d   = WAKE_LD;
               state_d = S_WAKE;
            end
         end
         S_WAKE: begin
            // A requester that gives up while the branch settles never sees a grant.
            if (!owner_req) begin
               ptr_d   = owner_q + 2'd1;
               cnt_d   = DRAIN_LD;
               state_d = S_DRAIN;
            end else if (cnt_q == 8'd0) begin
               hold_d  = 8'd1;
               state_d = S_GRANT;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_GRANT: begin
            if (release_now) begin
               ptr_d   = owner_q + 2'd1;
               cnt_d   = DRAIN_LD;
               hold_d  = 8'd0;
               state_d = S_DRAIN;
            end else if (hold_q != HOLD_MAX) begin
               hold_d = hold_q + 8'd1;
            end
         end
         S_DRAIN: begin
            if (cnt_q == 8'd0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register on the same edge as the state.
   always_comb begin
      gnt_d  = 4'b0000;
      e_d    = 1'b0;
      busy_d = (state_d != S_IDLE);
      case (state_d)
         S_WAKE:  e_d = 1'b1;
         S_GRANT: begin
            e_d            = 1'b1;
            gnt_d[owner_d] = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.GNT  = gnt_q;
   assign bus.E    = e_q;
   assign bus.BUSY = busy_q;

   a_gnt_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot0(gnt_q));
   a_gnt_needs_e: assert property (@(posedge CLK) disable iff (RST) (|gnt_q) |-> e_q);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkbr_arb4.sv
// Scoreboard bench for the clock-branch arbiter: expected grants (owner + edge) are queued
// by the stimulus and matched by an independent grant monitor.
module tb_gf180mcu_fd_sc_mcu7t5v0__clkbr_arb4;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   int   edge_n = 0;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   viol   = 0;
   int   base;
   logic [3:0] gnt_prev = 4'b0000;

   typedef struct {
      logic [3:0] gnt;
      int         edge_at;
   } exp_t;
   exp_t sb[$];

   gf180mcu_fd_sc_mcu7t5v0__clkbr_arb4_if bus();

   gf180mcu_fd_sc_mcu7t5v0__clkbr_arb4 #(
      .WAKE_CYC (2),
      .MAX_HOLD (4),
      .DRAIN_CYC(1)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) edge_n <= edge_n + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t edge=%0d)", name, act, exp, $time, edge_n);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic expect_grant(input logic [3:0] g, input int at);
      exp_t e;
      e.gnt     = g;
      e.edge_at = at;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      bus.REQ = 4'b0000;
      #1 RST = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   // Grant monitor: every new nonzero GNT must match the head of the scoreboard.
   always @(negedge CLK) begin
      exp_t e;
      if (!RST) begin
         if ((bus.GNT & (bus.GNT - 4'd1)) != 4'd0) viol++;
         if (bus.GNT != 4'd0 && !bus.E) viol++;
         if (bus.GNT != gnt_prev && bus.GNT != 4'd0) begin
            if (sb.size() == 0) begin
               chk("unexpected_grant", int'(bus.GNT), 0);
            end else begin
               e = sb.pop_front();
               chk("grant_owner", int'(bus.GNT), int'(e.gnt));
               chk("grant_edge", edge_n, e.edge_at);
            end
         end
      end
      gnt_prev = bus.GNT;
   end

   initial begin
      bus.REQ = 4'b0000;
      #1 RST = 1'b1;
      #1;
      chk("reset_gnt", int'(bus.GNT), 0);
      chk("reset_e", int'(bus.E), 0);
      chk("reset_busy", int'(bus.BUSY), 0);
      step(2);
      RST = 1'b0;

      // Single request, full wake/grant/release/drain timeline.
      base = edge_n;
      bus.REQ = 4'b0001;
      expect_grant(4'b0001, base + 3);
      step(1);
      chk("single_e_rise", int'(bus.E), 1);
      chk("single_busy", int'(bus.BUSY), 1);
      chk("single_no_gnt_in_wake", int'(bus.GNT), 0);
      step(8);
      chk("single_gnt_held", int'(bus.GNT), 1);
      bus.REQ = 4'b0000;
      step(1);
      chk("single_gnt_drop", int'(bus.GNT), 0);
      chk("single_e_drop", int'(bus.E), 0);
      chk("single_busy_drain", int'(bus.BUSY), 1);
      step(1);
      chk("single_busy_fall", int'(bus.BUSY), 0);

      // Round robin with all four requesting.
      do_reset();
      base = edge_n;
      bus.REQ = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         expect_grant(4'b0001 << (k % 4), base + 3 + 6 * k);
         step(4);
         bus.REQ = 4'b1111 & ~(4'b0001 << (k % 4));
         step(1);
         chk("rr_e_off_in_drain", int'(bus.E), 0);
         bus.REQ = 4'b1111;
         step(1);
      end
      bus.REQ = 4'b0000;
      step(3);
      chk("rr_idle_after", int'(bus.BUSY), 0);

      // WAKE abort: owner 2 gives up, pointer must advance to 3.
      do_reset();
      base = edge_n;
      bus.REQ = 4'b0100;
      step(1);
      chk("abort_e_in_wake", int'(bus.E), 1);
      bus.REQ = 4'b0000;
      step(1);
      chk("abort_e_low", int'(bus.E), 0);
      chk("abort_gnt_zero", int'(bus.GNT), 0);
      chk("abort_busy_drain", int'(bus.BUSY), 1);
      bus.REQ = 4'b1101;
      expect_grant(4'b1000, base + 6);
      step(5);
      bus.REQ = 4'b0000;
      step(2);
      chk("abort_idle_after", int'(bus.BUSY), 0);

      // Owner 0 holds while requester 3 waits.
      do_reset();
      base = edge_n;
      bus.REQ = 4'b0001;
      expect_grant(4'b0001, base + 3);
      step(3);
      bus.REQ = 4'b1001;
`ifdef GF180MCU_FD_SC_MCU7T5V0_CLKBR_ARB_PREEMPT_EN
      expect_grant(4'b1000, base + 11);
`endif
      step(3);
      chk("hold_gnt0_before_limit", int'(bus.GNT), 1);
      step(1);
`ifdef GF180MCU_FD_SC_MCU7T5V0_CLKBR_ARB_PREEMPT_EN
      chk("preempt_gnt_drop", int'(bus.GNT), 0);
      chk("preempt_e_drop", int'(bus.E), 0);
`else
      chk("nopreempt_gnt_held", int'(bus.GNT), 1);
`endif
      step(4);
`ifdef GF180MCU_FD_SC_MCU7T5V0_CLKBR_ARB_PREEMPT_EN
      chk("preempt_gnt3", int'(bus.GNT), 8);
      step(1);
      bus.REQ = 4'b0001;
      expect_grant(4'b0001, base + 17);
`else
      chk("nopreempt_gnt_still", int'(bus.GNT), 1);
      step(1);
`endif
      step(28);
      chk("owner0_holding", int'(bus.GNT), 1);

      // Asynchronous reset in the middle of a grant, between clock edges.
      #2 RST = 1'b1;
      #1;
      chk("async_rst_gnt", int'(bus.GNT), 0);
      chk("async_rst_e", int'(bus.E), 0);
      chk("async_rst_busy", int'(bus.BUSY), 0);
      bus.REQ = 4'b0110;
      @(negedge CLK);
      RST = 1'b0;
      base = edge_n;
      expect_grant(4'b0010, base + 3);
      step(4);
      bus.REQ = 4'b0000;
      step(4);
      chk("final_idle", int'(bus.BUSY), 0);

      chk("grants_outstanding", sb.size(), 0);
      chk("invariant_violations", viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
